// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-limited arbiter sharing one FIFO write port
// Grant state is registered; ready, write enable and write data are decoded from it combinationally.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full_flag,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          grant_active,
    output logic [GW-1:0]                 grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [CW-1:0] beat_cnt;

    logic          transfer;
    logic          release_grant;
    logic [GW-1:0] next_ptr;
    logic          idle_found;
    logic [GW-1:0] idle_pick;
    logic          rel_found;
    logic [GW-1:0] rel_pick;

    // Returns {found, index} of the first valid requester at or after start, wrapping.
    function automatic logic [GW:0] rr_select(input logic [NUM_REQ-1:0] valid,
                                              input logic [GW-1:0]      start);
        logic [GW:0]   result;
        logic [GW-1:0] idx;
        result = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(start) + k) % NUM_REQ);
            if (valid[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign {idle_found, idle_pick} = rr_select(req_valid, rr_ptr);
    assign {rel_found, rel_pick}   = rr_select(req_valid, next_ptr);

    assign transfer = (state == GRANT) && req_valid[grant_id] && !full_flag;

    // Stalled cycles never advance beat_cnt, so only real transfers count toward the burst.
    assign release_grant = (state == GRANT) &&
                           ((transfer && (beat_cnt == CW'(MAX_BURST - 1))) || !req_valid[grant_id]);

    always_comb begin
        req_ready = '0;
        write_en  = 1'b0;
        data_in   = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = ~full_flag;
            write_en            = req_valid[grant_id] & ~full_flag;
            data_in             = req_data[grant_id * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant_id     <= '0;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            grant_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_found) begin
                        state        <= GRANT;
                        grant_id     <= idle_pick;
                        beat_cnt     <= '0;
                        grant_active <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        // Back-to-back hand-over: the next owner is chosen in the release edge.
                        if (rel_found) begin
                            grant_id <= rel_pick;
                        end else begin
                            state        <= IDLE;
                            grant_active <= 1'b0;
                        end
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
// A queue-based producer/FIFO environment and a round-robin reference model predict every output.
module tb_fifo_write_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic            full_flag;

    logic [NR-1:0] ready4, ready2;
    logic          we4, we2;
    logic [DW-1:0] din4, din2;
    logic          ga4, ga2;
    logic [1:0]    gid4, gid2;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) u4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready4), .full_flag(full_flag), .write_en(we4), .data_in(din4),
        .grant_active(ga4), .grant_id(gid4)
    );

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(2)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready2), .full_flag(full_flag), .write_en(we2), .data_in(din2),
        .grant_active(ga2), .grant_id(gid2)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] src [NR][$];
    logic [7:0] fifo[$];
    logic [7:0] exp_fifo[$];
    bit         held [NR];
    bit         acc [NR];
    bit         free_run, rand_gap, use_fifo, man_full, rd_en, seq_check;
    logic       we_s;
    logic [7:0] din_s;
    int         m_busy, m_g, m_ptr, m_beats;
    int         pops;
    int         next_seq [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_beats = 0;
    endtask

    // Reference behaviour at a clock edge, from the inputs seen at that edge.
    task automatic model_edge();
        int  p;
        bit  xfer;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_busy == 0) begin
            p = rr_pick(req_valid, m_ptr);
            if (p >= 0) begin
                m_busy = 1; m_g = p; m_beats = 0;
            end
        end else begin
            xfer = req_valid[m_g] && !full_flag;
            if (xfer) begin
                m_beats++;
                exp_fifo.push_back(req_data[m_g*DW +: DW]);
            end
            if ((xfer && m_beats == MB) || !req_valid[m_g]) begin
                m_ptr   = (m_g + 1) % NR;
                m_beats = 0;
                p = rr_pick(req_valid, m_ptr);
                if (p >= 0) m_g = p;
                else m_busy = 0;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (free_run) begin
                req_valid[i]        = 1'b1;
                req_data[i*DW +: DW] = 8'h50 + 8'(i);
            end else if (src[i].size() > 0 && (held[i] || !rand_gap || $urandom_range(3) != 0)) begin
                req_valid[i]        = 1'b1;
                req_data[i*DW +: DW] = src[i][0];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
        full_flag = use_fifo ? (fifo.size() >= DEPTH) : man_full;
    endtask

    task automatic check_outputs();
        logic [NR-1:0] er;
        logic          ew;
        logic [7:0]    ed;
        if (reset) model_reset();
        er = '0; ew = 1'b0; ed = '0;
        if (m_busy != 0) begin
            if (!full_flag) er[m_g] = 1'b1;
            ew = req_valid[m_g] & ~full_flag;
            ed = req_data[m_g*DW +: DW];
        end
        chk("write_en", 32'(we4), 32'(ew));
        chk("req_ready", 32'(ready4), 32'(er));
        chk("data_in", 32'(din4), 32'(ed));
        chk("grant_active", 32'(ga4), 32'(m_busy != 0));
        chk("grant_id", 32'(gid4), m_g);
        chk("rr_ptr", 32'(u4.rr_ptr), m_ptr);
        chk("beat_cnt", 32'(u4.beat_cnt), m_beats);
    endtask

    task automatic half();
        drive();
        @(negedge clk);
        for (int i = 0; i < NR; i++) acc[i] = req_valid[i] & ready4[i];
        we_s  = we4;
        din_s = din4;
        check_outputs();
    endtask

    task automatic edge_adv();
        logic [7:0] x, e;
        @(posedge clk);
        model_edge();
        if (reset) begin
            for (int i = 0; i < NR; i++) held[i] = 1'b0;
        end else begin
            if (we_s) fifo.push_back(din_s);
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && !free_run && src[i].size() > 0) x = src[i].pop_front();
                held[i] = req_valid[i] && !acc[i];
            end
        end
        if (rd_en && fifo.size() > 0) begin
            x = fifo.pop_front();
            pops++;
            e = (exp_fifo.size() > 0) ? exp_fifo.pop_front() : 8'hxx;
            chk("fifo_order", 32'(x), 32'(e));
            if (seq_check) begin
                chk("prod_order", 32'(x[5:0]), next_seq[x[7:6]]);
                next_seq[x[7:6]]++;
            end
        end
        #1;
    endtask

    task automatic cycle();
        half();
        edge_adv();
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NR; i++) begin
            src[i].delete();
            held[i]     = 1'b0;
            next_seq[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        free_run = 0; rand_gap = 0; use_fifo = 0; man_full = 0; rd_en = 0; seq_check = 0;
        clear_srcs();
        fifo.delete();
        exp_fifo.delete();
        pops = 0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    function automatic bit any_src();
        for (int i = 0; i < NR; i++) if (src[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int ids [3];
        int cnt [NR];
        int budget;
        logic [7:0] v8;

        reset = 1'b1; req_valid = '0; req_data = '0; full_flag = 1'b0;
        we_s = 1'b0; din_s = '0; pops = 0;
        model_reset();
        clear_srcs();

        // Reset state
        half();
        chk("rst_write_en", 32'(we4), 0);
        chk("rst_ready", 32'(ready4), 0);
        chk("rst_data_in", 32'(din4), 0);
        chk("rst_grant_active", 32'(ga4), 0);
        chk("rst_grant_id", 32'(gid4), 0);
        edge_adv();
        do_reset();

        // Single producer, 6 beats with MAX_BURST=4
        for (int k = 0; k < 6; k++) src[2].push_back(8'hA0 + 8'(k));
        half();
        chk("t1_not_yet", 32'(ga4), 0);
        edge_adv();
        for (int k = 0; k < 6; k++) begin
            half();
            chk("t1_we", 32'(we4), 1);
            chk("t1_data", 32'(din4), 32'hA0 + k);
            chk("t1_gid", 32'(gid4), 2);
            edge_adv();
        end
        cycle();
        half();
        chk("t1_idle", 32'(ga4), 0);
        edge_adv();
        chk("t1_fifo_size", fifo.size(), 6);
        for (int k = 0; k < 6; k++) begin
            v8 = fifo[k];
            chk("t1_fifo", 32'(v8), 32'hA0 + k);
        end

        // Fairness with MAX_BURST=2
        do_reset();
        free_run = 1'b1;
        cycle();
        for (int k = 0; k < 10; k++) begin
            half();
            chk("t2_gid", 32'(gid2), (k / 2) % NR);
            chk("t2_we", 32'(we2), 1);
            edge_adv();
        end

        // Full stall mid-burst
        do_reset();
        for (int k = 0; k < 4; k++) src[1].push_back(8'hB0 + 8'(k));
        cycle();
        for (int k = 0; k < 2; k++) begin
            half();
            chk("t3_pre_we", 32'(we4), 1);
            edge_adv();
        end
        man_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half();
            chk("t3_stall_we", 32'(we4), 0);
            chk("t3_stall_ready", 32'(ready4[1]), 0);
            chk("t3_stall_beats", 32'(u4.beat_cnt), 2);
            chk("t3_stall_gid", 32'(gid4), 1);
            edge_adv();
        end
        man_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            half();
            chk("t3_post_we", 32'(we4), 1);
            chk("t3_post_data", 32'(din4), 32'hB2 + k);
            edge_adv();
        end
        cycle();
        half();
        chk("t3_released", 32'(ga4), 0);
        chk("t3_rr_ptr", 32'(u4.rr_ptr), 2);
        edge_adv();

        // Early release on valid drop
        do_reset();
        src[0].push_back(8'hC0);
        src[3].push_back(8'hD0);
        src[3].push_back(8'hD1);
        cycle();
        half();
        chk("t4_first", 32'(din4), 32'hC0);
        edge_adv();
        half();
        chk("t4_drop_we", 32'(we4), 0);
        edge_adv();
        half();
        chk("t4_gid", 32'(gid4), 3);
        chk("t4_rr_ptr", 32'(u4.rr_ptr), 1);
        chk("t4_data", 32'(din4), 32'hD0);
        edge_adv();
        repeat (3) cycle();

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 6; k++) src[i].push_back(8'(i * 16 + k));
        repeat (7) cycle();
        half();
        chk("t5_mid_gid", 32'(gid4), 1);
        chk("t5_mid_we", 32'(we4), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_we", 32'(we4), 0);
        chk("t5_rst_ready", 32'(ready4), 0);
        chk("t5_rst_ga", 32'(ga4), 0);
        chk("t5_rst_data", 32'(din4), 0);
        chk("t5_rst_ga2", 32'(ga2), 0);
        edge_adv();
        reset = 1'b0;
        clear_srcs();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 2; k++) src[i].push_back(8'h80 + 8'(i * 16 + k));
        cycle();
        half();
        chk("t5_regrant_gid", 32'(gid4), 0);
        chk("t5_regrant_data", 32'(din4), 32'h80);
        edge_adv();
        repeat (12) cycle();

        // Random fill/drain through a 16-deep FIFO with throttled reads
        do_reset();
        use_fifo = 1'b1; rand_gap = 1'b1; seq_check = 1'b1;
        ids[0] = 0; ids[1] = 1; ids[2] = 3;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int n = 0; n < 100; n++) begin
            int id;
            id = ids[$urandom_range(2)];
            src[id].push_back(8'(id * 64 + cnt[id]));
            cnt[id]++;
        end
        budget = 0;
        while ((any_src() || fifo.size() > 0) && budget < 4000) begin
            rd_en = any_src() ? ($urandom_range(2) == 0) : 1'b1;
            cycle();
            budget++;
        end
        chk("t6_budget", 32'(budget < 4000), 1);
        chk("t6_pops", pops, 100);
        chk("t6_exp_left", exp_fifo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
